seq_cpu_core: RTL
=================

Name: seq_cpu_core

Overview:
- Parametrised multi-cycle processor core.
- Successor to the fixed 16-bit fetch/halt core: data width and PC width are configurable, it has an eight-entry register file, a small ALU/branch ISA, a start/done handshake and illegal-opcode trapping.
- Instructions come from an external synchronous instruction ROM; results leave on a registered output port with a valid strobe.
- Used by the lab top level and the task benches.

Parameters:
- DATA_W, 16, register/ALU/out width; legal range 8..32.
- ADDR_W, 8, PC and imem address width; legal range 1..8, since jump targets come from imm8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution; sampled only in IDLE or HALTED.
- start_pc  in  ADDR_W  first instruction address; sampled with start.
- imem_addr  out  ADDR_W  instruction ROM address.
- imem_rdata  in  16  ROM word; valid one cycle after imem_addr is presented.
- out  out  DATA_W  last value written by OUT.
- out_valid  out  1  one-cycle pulse when out updates.
- busy  out  1  high in FETCH/DECODE/EXEC.
- done  out  1  high while in HALTED.
- illegal  out  1  high in HALTED if halt was caused by an undefined opcode.

Behaviour:
- Reset (synchronous):
  - state=IDLE, pc=0, ir=0, R0..R7=0.
  - out=0, out_valid=0, busy=0, done=0, illegal=0, imem_addr=0.
  - Reset wins over every other event, including mid-instruction; no register or out update completes in the reset cycle.
- Instruction format (16 bits): op[15:12], rd[11:9], rs[8:6], imm8[7:0]. rs and imm8 overlap; each opcode uses only one of them.
- ISA:
  - 0 NOP.
  - 1 LDI: R[rd] <= zero-extended imm8, truncated to DATA_W.
  - 2 ADD: R[rd] <= R[rd]+R[rs] mod 2^DATA_W.
  - 3 SUB: R[rd] <= R[rd]-R[rs] mod 2^DATA_W.
  - 4 OUT: out <= R[rd]; out_valid pulses.
  - 5 JMP: pc <= imm8[ADDR_W-1:0].
  - 6 BNZ: if R[rd]!=0 then pc <= imm8[ADDR_W-1:0], else pc+1.
  - 7 HALT.
  - 8..15 illegal: treated as HALT and sets illegal.
- No flags. R0 is an ordinary register (not hardwired zero).
- FSM states:
  - IDLE: start=1 -> pc<=start_pc, illegal<=0, go to FETCH.
  - FETCH: imem_addr=pc -> DECODE.
  - DECODE: ir<=imem_rdata -> EXEC.
  - EXEC: execute ir. Non-branch ops set pc<=pc+1, wrapping mod 2^ADDR_W. Next state is FETCH, or HALTED for HALT/illegal; pc is not advanced on halt.
  - HALTED: done=1. start=1 -> pc<=start_pc, illegal<=0, go to FETCH (restart). Registers are not cleared on restart.
- Timing:
  - Exactly 3 cycles per instruction, no stalls.
  - out and out_valid are registered and asserted in the cycle after the OUT EXEC cycle.
  - busy and done are decoded from the registered state.
- start asserted in FETCH/DECODE/EXEC is ignored.
- imem_addr holds pc in every state. The ROM may be read any time; only DECODE latches its data.
- ADD/SUB with rd==rs use the old value for both operands (e.g. SUB r1,r1 -> 0).

Test Plan:
- Countdown program, start_pc=0: ROM[0..5] = 1205,1401,4200,3280,6202,7000 (hex); start pulsed one cycle.
  -> out_valid pulses 5 times with out = 5,4,3,2,1.
  -> done rises exactly 54 clock edges after the edge that sampled start.
  -> busy=0 and illegal=0 after halt.
- PC wrap, ADDR_W=8: start_pc=255, ROM[255]=0000 (NOP), ROM[0]=7000.
  -> imem_addr shows 255 then 0; done after 6 edges.
- Illegal opcode: ROM[0]=F123.
  -> HALTED with illegal=1, out still 0, done=1.
  -> Then start with start_pc=1, ROM[1]=7000 -> illegal clears, done after 3 edges.
- ALU wrap, DATA_W=8: program LDI r1,FF; LDI r2,01; ADD r1,r2; OUT r1; HALT.
  -> out=0x00.
  -> Variant with SUB from 0 gives out=0xFF.
- Reset mid-operation: assert rst during the EXEC cycle of an OUT.
  -> Next cycle: out=0, out_valid=0, state IDLE, busy=0, done=0.
  -> start is then required to run again.
- Ignored start: pulse start with start_pc=7 during the countdown run.
  -> Output sequence and halt timing are unchanged from the first scenario.

Source files
------------

// File: rtl/seq_cpu_core.sv
// Multi-cycle processor core: FETCH/DECODE/EXEC sequencing over an external synchronous ROM,
// eight-entry register file, small ALU/branch ISA, start/done handshake and illegal-opcode trap.
module seq_cpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_OUT  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_BNZ  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, pc_inc, jump_target;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   regs [8];

  logic [3:0]          op;
  logic [2:0]          rd, rs;
  logic [7:0]          imm8;
  logic [DATA_W-1:0]   rd_val, rs_val;

  logic                ir_load;
  logic                reg_we;
  logic [DATA_W-1:0]   reg_wdata;
  logic                out_we;
  logic                illegal_set;
  logic                illegal_clr;

  assign op          = ir[15:12];
  assign rd          = ir[11:9];
  assign rs          = ir[8:6];
  assign imm8        = ir[7:0];
  assign rd_val      = regs[rd];
  assign rs_val      = regs[rs];
  assign pc_inc      = pc + ADDR_W'(1);
  assign jump_target = imm8[ADDR_W-1:0];

  assign imem_addr = pc;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign done      = (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Both operands are read from the register file before the write lands, so rd==rs uses old values.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_load     = 1'b0;
    reg_we      = 1'b0;
    reg_wdata   = '0;
    out_we      = 1'b0;
    illegal_set = 1'b0;
    illegal_clr = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_n     = S_FETCH;
          pc_n        = start_pc;
          illegal_clr = 1'b1;
        end
      end
      S_FETCH: begin
        state_n = S_DECODE;
      end
      S_DECODE: begin
        state_n = S_EXEC;
        ir_load = 1'b1;
      end
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc_inc;
        case (op)
          OP_NOP: begin
          end
          OP_LDI: begin
            reg_we    = 1'b1;
            reg_wdata = DATA_W'(imm8);
          end
          OP_ADD: begin
            reg_we    = 1'b1;
            reg_wdata = rd_val + rs_val;
          end
          OP_SUB: begin
            reg_we    = 1'b1;
            reg_wdata = rd_val - rs_val;
          end
          OP_OUT: begin
            out_we = 1'b1;
          end
          OP_JMP: begin
            pc_n = jump_target;
          end
          OP_BNZ: begin
            if (rd_val != '0) begin
              pc_n = jump_target;
            end
          end
          OP_HALT: begin
            state_n = S_HALTED;
            pc_n    = pc;
          end
          default: begin
            state_n     = S_HALTED;
            pc_n        = pc;
            illegal_set = 1'b1;
          end
        endcase
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Reset has priority, so an instruction caught mid-flight never commits anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      pc        <= pc_n;
      out_valid <= out_we;
      if (ir_load) begin
        ir <= imem_rdata;
      end
      if (reg_we) begin
        regs[rd] <= reg_wdata;
      end
      if (out_we) begin
        out <= rd_val;
      end
      if (illegal_set) begin
        illegal <= 1'b1;
      end else if (illegal_clr) begin
        illegal <= 1'b0;
      end
    end
  end

endmodule
